// File: rtl/bist_pkg.sv
// bist_pkg
//   Types and helpers shared by the BIST sequencer and its MISR.
//   - bist_state_t : sequencer states
//   - MISR_WIDTH   : width of the response compactor
//   - MISR_TAPS    : feedback taps of the compactor (bits 7,5,4,3)
//   - cnt_width()  : bit width needed to count to n-1 (never below 1)
//   - misr_step()  : one serial compaction step
package bist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT,
      ST_SHIFT,
      ST_CAPTURE,
      ST_UNLOAD,
      ST_DONE
   } bist_state_t;

   localparam int MISR_WIDTH = 8;
   localparam logic [MISR_WIDTH-1:0] MISR_TAPS = 8'hB8;

   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // next = {m[6:0], m[7]^m[5]^m[4]^m[3]^d}
   function automatic logic [MISR_WIDTH-1:0] misr_step(input logic [MISR_WIDTH-1:0] m,
                                                       input logic d);
      return {m[MISR_WIDTH-2:0], (^(m & MISR_TAPS)) ^ d};
   endfunction

endpackage

// File: rtl/bist_misr.sv
// bist_misr
//   Serial multiple-input signature register compacting the scan chain output.
//   Ports:
//     clock     in   rising-edge clock
//     reset     in   asynchronous active-low reset
//     clear     in   synchronous clear (wins over enable)
//     enable    in   compact serial_in this cycle
//     serial_in in   scan chain serial output
//     signature out  current MISR contents
module bist_misr
   import bist_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic                  serial_in,
   output logic [MISR_WIDTH-1:0] signature
);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)      signature <= '0;
      else if (clear)  signature <= '0;
      else if (enable) signature <= misr_step(signature, serial_in);
   end

endmodule

// File: rtl/bist_controller.sv
// bist_controller
//   Sequences one BIST run: clear the pattern LFSR, then PATTERN_COUNT times
//   shift CHAIN_LENGTH bits into the scan chain and pulse one capture cycle,
//   and finally unload the last response.
//   Optional build macro BIST_MISR_EN adds an 8-bit MISR over scan_out and a
//   pass flag against GOLDEN_SIGNATURE; without it signature and pass are 0.
//   Ports:
//     clock, reset   clock / asynchronous active-low reset
//     start          level, accepted in IDLE or DONE
//     abort          synchronous return to IDLE from any other state
//     scan_out       serial output of the scan chain
//     lfsr_reset     synchronous clear to the LFSR (INIT)
//     lfsr_mode      LFSR advance enable (SHIFT)
//     scan_enable    chain shift mode (SHIFT, UNLOAD)
//     capture        one-cycle functional capture strobe
//     busy, done     run in progress / run complete (held)
//     pattern_index  current pattern number
//     signature      MISR contents
//     pass           signature == GOLDEN_SIGNATURE, valid with done
//   Every output is a flop: strobes are decoded from the next state and
//   registered, so they line up exactly with the state they belong to.
module bist_controller
   import bist_pkg::*;
#(
   parameter int          CHAIN_LENGTH     = 16,
   parameter int          PATTERN_COUNT    = 64,
   parameter logic [7:0]  GOLDEN_SIGNATURE = 8'h00
)(
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           scan_out,
   output logic                           lfsr_reset,
   output logic                           lfsr_mode,
   output logic                           scan_enable,
   output logic                           capture,
   output logic                           busy,
   output logic                           done,
   output logic [$clog2(PATTERN_COUNT):0] pattern_index,
   output logic [7:0]                     signature,
   output logic                           pass
);

   localparam int SHIFT_W = cnt_width(CHAIN_LENGTH + 1);
   localparam int PIDX_W  = $clog2(PATTERN_COUNT) + 1;
   localparam logic [SHIFT_W-1:0] SHIFT_LAST = SHIFT_W'(CHAIN_LENGTH - 1);
   localparam logic [PIDX_W-1:0]  PIDX_LAST  = PIDX_W'(PATTERN_COUNT - 1);

   bist_state_t        state, state_nx;
   logic [SHIFT_W-1:0] shift_cnt;
   logic               shift_last, pidx_last, abort_hit;
   logic               lr_nx, lm_nx, se_nx, cap_nx, busy_nx, done_nx;

   assign shift_last = (shift_cnt == SHIFT_LAST);
   assign pidx_last  = (pattern_index == PIDX_LAST);
   assign abort_hit  = abort && (state != ST_IDLE);

   // ---- state and registered strobes ----
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         lfsr_reset  <= 1'b0;
         lfsr_mode   <= 1'b0;
         scan_enable <= 1'b0;
         capture     <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         state       <= state_nx;
         lfsr_reset  <= lr_nx;
         lfsr_mode   <= lm_nx;
         scan_enable <= se_nx;
         capture     <= cap_nx;
         busy        <= busy_nx;
         done        <= done_nx;
      end
   end

   // ---- next state; abort overrides start and terminal counts ----
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (start) state_nx = ST_INIT;
         ST_INIT:    state_nx = ST_SHIFT;
         ST_SHIFT:   if (shift_last) state_nx = ST_CAPTURE;
         ST_CAPTURE: state_nx = pidx_last ? ST_UNLOAD : ST_SHIFT;
         ST_UNLOAD:  if (shift_last) state_nx = ST_DONE;
         ST_DONE:    if (start) state_nx = ST_INIT;
         default:    state_nx = ST_IDLE;
      endcase
      if (abort_hit) state_nx = ST_IDLE;
   end

   // ---- strobe decode of the state being entered ----
   always_comb begin
      lr_nx   = 1'b0;
      lm_nx   = 1'b0;
      se_nx   = 1'b0;
      cap_nx  = 1'b0;
      busy_nx = 1'b0;
      done_nx = 1'b0;
      case (state_nx)
         ST_INIT:    begin lr_nx = 1'b1; busy_nx = 1'b1; end
         ST_SHIFT:   begin se_nx = 1'b1; lm_nx = 1'b1; busy_nx = 1'b1; end
         ST_CAPTURE: begin cap_nx = 1'b1; busy_nx = 1'b1; end
         ST_UNLOAD:  begin se_nx = 1'b1; busy_nx = 1'b1; end
         ST_DONE:    done_nx = 1'b1;
         default:    ;
      endcase
   end

   // Shared SHIFT/UNLOAD bit counter: restarts at 0 on every state change,
   // so each SHIFT and the UNLOAD burst see a fresh 0..CHAIN_LENGTH-1 count.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         shift_cnt <= '0;
      else if (state_nx != state)
         shift_cnt <= '0;
      else if (state == ST_SHIFT || state == ST_UNLOAD)
         shift_cnt <= shift_cnt + 1'b1;
   end

   // Pattern counter: zero on entry to INIT and on abort, advances at the
   // end of each CAPTURE that is not the last one.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         pattern_index <= '0;
      else if (abort_hit || state_nx == ST_INIT)
         pattern_index <= '0;
      else if (state == ST_CAPTURE && !pidx_last)
         pattern_index <= pattern_index + 1'b1;
   end

`ifdef BIST_MISR_EN
   logic                  misr_clear, misr_en;
   logic [MISR_WIDTH-1:0] misr_q;

   // Clearing on entry to INIT makes signature read 0 throughout INIT.
   assign misr_clear = abort_hit || (state_nx == ST_INIT);
   // The first SHIFT unloads nothing meaningful, so compaction starts with
   // pattern 1 and covers every UNLOAD cycle.
   assign misr_en    = (state == ST_UNLOAD) ||
                       (state == ST_SHIFT && pattern_index != '0);

   bist_misr u_misr (
      .clock     (clock),
      .reset     (reset),
      .clear     (misr_clear),
      .enable    (misr_en),
      .serial_in (scan_out),
      .signature (misr_q)
   );

   assign signature = misr_q;

   // pass is evaluated on the final UNLOAD edge, against the value the MISR
   // is taking on that same edge, so it is valid from the first DONE cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         pass <= 1'b0;
      else if (misr_clear)
         pass <= 1'b0;
      else if (state == ST_UNLOAD && state_nx == ST_DONE)
         pass <= (misr_step(misr_q, scan_out) == GOLDEN_SIGNATURE);
   end
`else
   logic [8:0] unused_cfg;
   assign unused_cfg = {scan_out, GOLDEN_SIGNATURE};
   assign signature  = 8'h00;
   assign pass       = 1'b0;
`endif

endmodule

// File: tb/tb_bist_controller.sv
// tb_bist_controller
//   Randomized-stimulus scoreboard bench for bist_controller (4x3 main
//   instance plus a 1x1 corner-case instance). The stimulus side builds each
//   run's scan_out stream, computes the expected run length, capture count,
//   signature and pass from the sequencing rules, and queues them; a monitor
//   follows the outputs every cycle against an arithmetic schedule model and
//   pops the queue when done rises.
module tb_bist_controller;

   localparam int C = 4;
   localparam int P = 3;
   localparam int L = 1 + P * (C + 1) + C;     // busy-rise to done-rise
   localparam int BODY = 1 + P * (C + 1);      // first UNLOAD offset
`ifdef BIST_MISR_EN
   localparam bit MISR_ON = 1'b1;
`else
   localparam bit MISR_ON = 1'b0;
`endif
   localparam logic [7:0] GOLDEN = 8'h00;

   typedef struct {
      int         len;
      int         caps;
      logic [7:0] sig;
      logic       pass;
   } exp_t;

   logic clock = 1'b0;
   logic reset, start, abort, scan_out;
   logic lfsr_reset, lfsr_mode, scan_enable, capture, busy, done, pass;
   logic [$clog2(P):0] pattern_index;
   logic [7:0] signature;

   logic start1, abort1, scan_out1;
   logic lfsr_reset1, lfsr_mode1, scan_enable1, capture1, busy1, done1, pass1;
   logic [0:0] pattern_index1;
   logic [7:0] signature1;

   exp_t sb[$];
   exp_t exp_last;
   bit   mon_en;
   int   checks = 0;
   int   failures = 0;

   always #5 clock = ~clock;

   bist_controller #(.CHAIN_LENGTH(C), .PATTERN_COUNT(P), .GOLDEN_SIGNATURE(GOLDEN)) dut (
      .clock(clock), .reset(reset), .start(start), .abort(abort), .scan_out(scan_out),
      .lfsr_reset(lfsr_reset), .lfsr_mode(lfsr_mode), .scan_enable(scan_enable),
      .capture(capture), .busy(busy), .done(done), .pattern_index(pattern_index),
      .signature(signature), .pass(pass)
   );

   bist_controller #(.CHAIN_LENGTH(1), .PATTERN_COUNT(1), .GOLDEN_SIGNATURE(GOLDEN)) dut1 (
      .clock(clock), .reset(reset), .start(start1), .abort(abort1), .scan_out(scan_out1),
      .lfsr_reset(lfsr_reset1), .lfsr_mode(lfsr_mode1), .scan_enable(scan_enable1),
      .capture(capture1), .busy(busy1), .done(done1), .pattern_index(pattern_index1),
      .signature(signature1), .pass(pass1)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, expv);
      end
   endtask

   function automatic logic [31:0] obs_vec();
      return 32'({lfsr_reset, lfsr_mode, scan_enable, capture, busy, done, 8'(pattern_index)});
   endfunction

   function automatic logic [31:0] obs_all();
      return 32'({lfsr_reset, lfsr_mode, scan_enable, capture, busy, done, pass,
                  8'(pattern_index), signature});
   endfunction

   // Expected strobes at cycle offset t after busy rises (t=0 is INIT).
   function automatic logic [31:0] model_vec(input int t);
      logic lr = 1'b0, lm = 1'b0, se = 1'b0, cap = 1'b0, bz = 1'b0, dn = 1'b0;
      int   pidx = 0;
      if (t == 0) begin
         lr = 1'b1; bz = 1'b1;
      end else if (t < BODY) begin
         bz = 1'b1;
         pidx = (t - 1) / (C + 1);
         if ((t - 1) % (C + 1) < C) begin se = 1'b1; lm = 1'b1; end
         else cap = 1'b1;
      end else if (t < L) begin
         bz = 1'b1; se = 1'b1; pidx = P - 1;
      end else begin
         dn = 1'b1; pidx = P - 1;
      end
      return 32'({lr, lm, se, cap, bz, dn, 8'(pidx)});
   endfunction

   // Caller is at the start of the INIT cycle. Drives one run's scan_out
   // stream (mode 0: all 0, 1: all 1, else random), queues the expectation,
   // and returns at the start of the DONE cycle.
   task automatic drive_run(input int mode, input int drop_at);
      logic       bits [0:L];
      logic [7:0] m = 8'h00;
      exp_t       e;
      for (int t = 0; t <= L; t++)
         bits[t] = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int t = 0; t < L; t++) begin
         bit in_misr;
         in_misr = (t >= BODY) ||
                   (t >= 1 && (t - 1) / (C + 1) >= 1 && (t - 1) % (C + 1) < C);
         if (in_misr) m = {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3] ^ bits[t]};
      end
      e.len  = L;
      e.caps = P;
      e.sig  = MISR_ON ? m : 8'h00;
      e.pass = MISR_ON ? (m == GOLDEN) : 1'b0;
      sb.push_back(e);
      exp_last = e;
      for (int t = 0; t < L; t++) begin
         if (t == drop_at) start = 1'b0;
         scan_out = bits[t];
         @(posedge clock); #1;
      end
   endtask

   task automatic pulse_run(input int mode);
      start = 1'b1;
      @(posedge clock); #1;
      chk("busy_rise", 32'(busy), 32'd1);
      drive_run(mode, 0);
   endtask

   task automatic held_checks(input string nm);
      repeat (3) @(posedge clock);
      #1;
      chk({nm, "_done_held"}, 32'({busy, done}), 32'd1);
      chk({nm, "_sig_held"}, 32'(signature), 32'(exp_last.sig));
      chk({nm, "_pass_held"}, 32'(pass), 32'(exp_last.pass));
      chk({nm, "_pidx_held"}, 32'(pattern_index), 32'(P - 1));
   endtask

   // Monitor / scoreboard consumer.
   initial begin
      bit   trk = 1'b0;
      int   t = 0;
      int   caps = 0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (!mon_en) begin
            trk = 1'b0;
         end else begin
            if (!trk && lfsr_reset) begin
               trk = 1'b1; t = 0; caps = 0;
            end
            if (trk) begin
               chk($sformatf("strobes_t%0d", t), obs_vec(), model_vec(t));
               if (capture) caps++;
               if (done) begin
                  if (sb.size() == 0) begin
                     chk("sb_underflow", 32'(sb.size()), 32'd1);
                  end else begin
                     e = sb.pop_front();
                     chk("run_len", 32'(t), 32'(e.len));
                     chk("capture_count", 32'(caps), 32'(e.caps));
                     chk("signature", 32'(signature), 32'(e.sig));
                     chk("pass", 32'(pass), 32'(e.pass));
                  end
                  trk = 1'b0;
               end else if (t >= 2 * L) begin
                  chk("run_timeout", 32'(t), 32'(L));
                  trk = 1'b0;
               end else begin
                  t++;
               end
            end
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] small_exp [0:4];
      reset = 1'b0; start = 1'b0; abort = 1'b0; scan_out = 1'b0;
      start1 = 1'b0; abort1 = 1'b0; scan_out1 = 1'b0;
      mon_en = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_outs", obs_all(), 32'd0);
      chk("reset_outs_small", 32'({lfsr_reset1, lfsr_mode1, scan_enable1, capture1,
                                   busy1, done1, pass1, pattern_index1, signature1}), 32'd0);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("idle_after_reset", obs_all(), 32'd0);

      // Pulsed runs with all-zero, all-one and random scan data.
      pulse_run(0); held_checks("zeros");
      pulse_run(1); held_checks("ones");
      pulse_run(2); held_checks("rand_a");
      pulse_run(2); held_checks("rand_b");

      // start held high: DONE restarts at once; start mid-run is ignored.
      start = 1'b1;
      @(posedge clock); #1;
      chk("held_busy_rise", 32'(busy), 32'd1);
      drive_run(2, -1);
      chk("held_done", 32'(done), 32'd1);
      @(posedge clock); #1;
      chk("restart_done_drop", 32'({done, lfsr_reset, busy}), 32'b011);
      drive_run(2, 6);
      held_checks("held_second");

      // Abort in the second SHIFT cycle of pattern 1, with start also high.
      mon_en = 1'b0;
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (C + 3) @(posedge clock);
      #1;
      chk("pre_abort", 32'({scan_enable, 8'(pattern_index)}), 32'h101);
      abort = 1'b1; start = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0; start = 1'b0;
      chk("abort_outs", obs_all(), 32'd0);
      repeat (2) @(posedge clock);
      #1;
      chk("abort_stays_idle", obs_all(), 32'd0);

      // Asynchronous reset in the middle of CAPTURE of pattern 0.
      start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (C + 1) @(posedge clock);
      #1;
      chk("pre_reset_capture", 32'(capture), 32'd1);
      #2 reset = 1'b0;
      #1 chk("async_reset_outs", obs_all(), 32'd0);
      @(posedge clock); #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk("post_reset_idle", obs_all(), 32'd0);
      mon_en = 1'b1;
      pulse_run(2); held_checks("after_reset");

      // Minimal configuration: INIT, SHIFT, CAPTURE, UNLOAD, DONE.
      small_exp = '{6'b100010, 6'b011010, 6'b000110, 6'b001010, 6'b000001};
      start1 = 1'b1;
      @(posedge clock); #1;
      start1 = 1'b0;
      for (int t = 0; t <= 4; t++) begin
         chk($sformatf("small_t%0d", t),
             32'({lfsr_reset1, lfsr_mode1, scan_enable1, capture1, busy1, done1}),
             32'(small_exp[t]));
         @(posedge clock); #1;
      end
      chk("small_result", 32'({signature1, pass1}), 32'({8'h00, MISR_ON}));

      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bist_controller.md
Name: bist_controller

Overview:
- Sequences the per-scan BIST loop: clears the 8-bit pattern LFSR, then shifts CHAIN_LENGTH pseudo-random bits into the scan chain and pulses one functional capture cycle.
- Repeats the shift/capture loop for PATTERN_COUNT patterns, then unloads the last response.
- Sits between the test-access logic (start/abort/status) and the LFSR plus the scan chain, which it drives through lfsr_reset, lfsr_mode, scan_enable and capture.

Parameters:
- CHAIN_LENGTH, 16: scan flops per chain; legal range ≥1.
- PATTERN_COUNT, 64: patterns applied per run; legal range ≥1.
- GOLDEN_SIGNATURE, 8'h00: expected MISR value. Used only with BIST_MISR_EN.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  level; sampled in IDLE or DONE to begin a run
- abort  input  1  synchronous; ends the run and returns to IDLE
- scan_out  input  1  serial output of the scan chain
- lfsr_reset  output  1  synchronous active-high clear to the LFSR
- lfsr_mode  output  1  LFSR advance enable
- scan_enable  output  1  chain in shift mode
- capture  output  1  one-cycle functional capture strobe
- busy  output  1  run in progress
- done  output  1  run complete, held
- pattern_index  output  $clog2(PATTERN_COUNT)+1  index of the current pattern
- signature  output  8  MISR contents (0 without BIST_MISR_EN)
- pass  output  1  signature==GOLDEN_SIGNATURE, valid when done=1

Behaviour:
- All outputs are registered. While reset is low, every output is 0 and the state is IDLE.
- States: IDLE, INIT, SHIFT, CAPTURE, UNLOAD, DONE.
- IDLE: all strobes 0. If start=1, go to INIT.
- INIT (1 cycle): lfsr_reset=1, busy=1. Shift counter, pattern_index and MISR are cleared. Go to SHIFT.
- SHIFT (CHAIN_LENGTH cycles):
  - scan_enable=1, lfsr_mode=1.
  - The shift counter runs 0..CHAIN_LENGTH-1. At the terminal count, go to CAPTURE.
  - The first bit shifted is the LFSR's reset value, 0.
- CAPTURE (1 cycle): scan_enable=0, lfsr_mode=0 (LFSR holds), capture=1.
  - If pattern_index==PATTERN_COUNT-1, go to UNLOAD.
  - Otherwise increment pattern_index and go to SHIFT. Each SHIFT after the first also unloads the previous response.
- UNLOAD (CHAIN_LENGTH cycles): scan_enable=1, lfsr_mode=0. Go to DONE.
- DONE: busy=0, done=1; signature and pass are held. Leave on start=1: go to INIT and clear done in the same transition.
- Run length: done rises 1+PATTERN_COUNT*(CHAIN_LENGTH+1)+CHAIN_LENGTH cycles after busy rises.
- start while busy=1: ignored.
- abort=1 in any state other than IDLE: the next state is IDLE and all strobes, busy and done go to 0.
  - abort takes priority over start and over terminal counts.
  - signature and pass also go to 0.
- Asynchronous reset asserted mid-run: immediate IDLE, all outputs 0. No partial result is retained.
- Counter widths:
  - Shift counter is $clog2(CHAIN_LENGTH+1) bits.
  - pattern_index is sized to hold PATTERN_COUNT-1 with no wrap.
  - CHAIN_LENGTH=1 and PATTERN_COUNT=1 must work.

Optional Feature:
- Macro BIST_MISR_EN.
- Defined:
  - An 8-bit serial MISR compacts scan_out on every cycle of SHIFT for patterns ≥1 and on every cycle of UNLOAD.
  - Update rule: next = {misr[6:0], misr[7]^misr[5]^misr[4]^misr[3]^scan_out}.
  - The MISR clears in INIT; signature=misr.
  - pass is registered on entry to DONE.
- Undefined: no MISR logic; signature is tied to 0 and pass is tied to 0. Sequencing is identical in both builds.

Decomposition:
- Package bist_pkg:
  - state enum bist_state_t;
  - MISR_WIDTH=8;
  - MISR tap constant 8'hB8;
  - a function for the counter width.
- Sub-module bist_misr (clock, reset, clear, enable, serial_in, signature), instantiated only under BIST_MISR_EN.
- The FSM and counters stay in bist_controller.

Test Plan:
- CHAIN_LENGTH=4, PATTERN_COUNT=3, pulse start:
  - busy rises 1 cycle after start is sampled; done rises 20 cycles later;
  - exactly 3 capture pulses, 4+1 cycles apart;
  - lfsr_reset high for exactly 1 cycle.
- Same configuration with start held high throughout: one run completes, then DONE immediately restarts (INIT) and done drops. start during SHIFT/CAPTURE has no effect.
- abort asserted in the 2nd SHIFT cycle of pattern 1: the next cycle is IDLE with busy=0, done=0, scan_enable=0 and pattern_index=0.
- reset driven low mid-CAPTURE: capture and all outputs go to 0 asynchronously. After release and start, a full 20-cycle run completes.
- BIST_MISR_EN, GOLDEN_SIGNATURE=8'h00, scan_out tied 0: signature=8'h00 and pass=1. With scan_out tied 1: signature≠0 and pass=0.
- CHAIN_LENGTH=1, PATTERN_COUNT=1: sequence INIT, SHIFT×1, CAPTURE, UNLOAD×1, DONE; done rises 4 cycles after busy.
